// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: ready/valid pipeline register with two-entry skid buffer, synchronous flush and saturating stall counter
module pipe_stage_skid #(
  parameter int               WIDTH  = 32,
  parameter logic [WIDTH-1:0] BUBBLE = '0,
  parameter int               CNT_W  = 16
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt
);
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t           state, state_nx;
  logic [WIDTH-1:0] main_q, skid_q;
  logic             in_fire, out_fire;
  assign in_fire   = in_valid & in_ready;
  assign out_valid = state != EMPTY;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = out_valid ? main_q : BUBBLE;
  always_comb begin
    state_nx = flush ? EMPTY :
               state == EMPTY ? (in_fire ? ONE : EMPTY) :
               state == ONE ? ((in_fire && !out_fire) ? FULL : (!in_fire && out_fire) ? EMPTY : ONE) :
               (out_fire ? ONE : FULL);
  end
  always_ff @(posedge CLK) begin
    if (reset) begin
      state     <= EMPTY;
      in_ready  <= 1'b1;
      stall_cnt <= '0;
    end else begin
      state    <= state_nx;
      in_ready <= state_nx != FULL;
      if (out_valid && !out_ready && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end
  end
  always_ff @(posedge CLK) begin
    if (in_fire && (state == EMPTY || out_fire)) main_q <= in_data;
    else if (state == FULL && out_fire) main_q <= skid_q;
    if (in_fire && !out_fire) skid_q <= in_data;
  end
endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb_pipe_stage_skid: scoreboard bench for pipe_stage_skid with a FIFO-occupancy reference model
module tb_pipe_stage_skid;
  localparam int WIDTH = 32;
  localparam int CNT_W = 3;
  localparam int CMAX  = (1 << CNT_W) - 1;
  logic             CLK = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] stall_cnt;
  int               n_tests = 0;
  int               n_fail = 0;
  logic [WIDTH-1:0] exp_q[$];
  int               cnt = 0;
  int               pre_sz = 0;
  bit               started = 0;
  pipe_stage_skid #(.WIDTH(WIDTH), .BUBBLE('0), .CNT_W(CNT_W)) dut (
    .CLK(CLK), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .stall_cnt(stall_cnt)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
    end
  endtask
  always @(negedge CLK) begin
    pre_sz = exp_q.size();
    if (started) begin
      chk("in_ready", {31'b0, in_ready}, {31'b0, exp_q.size() < 2});
      chk("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
      chk("stall_cnt", {29'b0, stall_cnt}, cnt);
      if (exp_q.size() == 0) chk("bubble", out_data, '0);
      else if (out_ready) chk("data", out_data, exp_q.pop_front());
      else chk("head", out_data, exp_q[0]);
    end
  end
  always @(posedge CLK) begin
    if (reset) begin
      started = 1;
      exp_q.delete();
      cnt = 0;
    end else begin
      if (pre_sz > 0 && !out_ready && cnt < CMAX) cnt++;
      if (flush) exp_q.delete();
      else if (in_valid && pre_sz < 2) exp_q.push_back(in_data);
    end
  end
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  task automatic send(input logic [WIDTH-1:0] d);
    bit ok;
    bit done = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 50 && !done; i++) begin
      ok = in_ready;
      tick();
      done = ok;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout data %h: in_ready never high, required accept within 50 cycles", d);
    end
    in_valid = 1'b0;
  endtask
  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask
  initial begin
    in_valid = 1'b1;
    in_data  = 32'hDEADBEEF;
    tick();
    tick();
    reset    = 1'b0;
    in_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data  = i;
      tick();
    end
    in_valid = 1'b0;
    tick();
    tick();
    send(32'h10);
    out_ready = 1'b0;
    send(32'h11);
    in_valid = 1'b1;
    in_data  = 32'h12;
    repeat (3) tick();
    out_ready = 1'b1;
    send(32'h12);
    repeat (4) tick();
    out_ready = 1'b0;
    send(32'hA1);
    send(32'hA2);
    in_valid = 1'b1;
    in_data  = 32'h55;
    flush    = 1'b1;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    tick();
    out_ready = 1'b1;
    repeat (2) tick();
    pulse_reset();
    out_ready = 1'b0;
    send(32'h77);
    repeat (10) tick();
    pulse_reset();
    tick();
    send(32'hA);
    send(32'hB);
    pulse_reset();
    out_ready = 1'b1;
    send(32'hC);
    repeat (2) tick();
    for (int i = 0; i < 3000; i++) begin
      in_valid  = $urandom_range(0, 9) < 7;
      in_data   = $urandom;
      out_ready = $urandom_range(0, 9) < 6;
      flush     = $urandom_range(0, 99) < 3;
      reset     = $urandom_range(0, 199) < 1;
      tick();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    reset     = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d entries still expected, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
